div_repeated_sub: RTL and testbench

//  Unsigned integer divider using repeated subtraction; the inverse companion of the repeated-addition multiplier.

---
 rtl/div_pkg.sv | 14 +
 rtl/div_datapath.sv | 54 +++++
 rtl/div_repeated_sub.sv | 86 ++++++++
 tb/tb_div_repeated_sub.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared constants for the repeated-subtraction divider:
// controller state encoding and the default operand width.
package div_pkg;

  localparam int DIV_WIDTH = 16;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LDA  = 3'd1;
  localparam logic [2:0] S_LDB  = 3'd2;
  localparam logic [2:0] S_CHK  = 3'd3;
  localparam logic [2:0] S_SUB  = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

endpackage

// File: rtl/div_datapath.sv
// Divider datapath: remainder/divisor/quotient registers, subtractor,
// ge-comparator and divisor zero-detect.
// Ports: clk, rst (sync, active-high), data_in (operand bus),
//   ldr/ldb/clrq/decr/incq/setq (controls), ge/bz (status),
//   quotient/remainder (registered results).
module div_datapath
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             ldr,
  input  logic             ldb,
  input  logic             clrq,
  input  logic             decr,
  input  logic             incq,
  input  logic             setq,
  output logic             ge,
  output logic             bz,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  logic [WIDTH-1:0] divisor;

  assign ge = (remainder >= divisor);
  assign bz = (divisor == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      remainder <= '0;
      divisor   <= '0;
      quotient  <= '0;
    end else begin
      if (ldr)
        remainder <= data_in;
      else if (decr)
        remainder <= remainder - divisor;

      if (ldb)
        divisor <= data_in;

      if (clrq)
        quotient <= '0;
      else if (setq)
        quotient <= '1;
      else if (incq)
        quotient <= quotient + 1'b1;
    end
  end

endmodule

// File: rtl/div_repeated_sub.sv
// Unsigned divider by repeated subtraction: controller FSM + datapath.
// Ports: clk, rst (sync, active-high), start, data_in (dividend then
//   divisor), quotient, remainder, busy, done, div_zero.
module div_repeated_sub
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  logic [2:0] state;
  logic [2:0] state_nx;
  logic       ge;
  logic       bz;
  logic       ldr;
  logic       ldb;
  logic       clrq;
  logic       decr;
  logic       incq;
  logic       setq;

  assign ldr  = (state == S_LDA);
  assign clrq = (state == S_LDA);
  assign ldb  = (state == S_LDB);
  assign setq = (state == S_CHK) && bz;
  assign decr = (state == S_SUB) && ge;
  assign incq = (state == S_SUB) && ge;

  assign busy = (state == S_LDA) || (state == S_LDB)
             || (state == S_CHK) || (state == S_SUB);
  assign done = (state == S_DONE);

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_LDA;
      S_LDA:   state_nx = S_LDB;
      S_LDB:   state_nx = S_CHK;
      S_CHK:   state_nx = bz ? S_DONE : S_SUB;
      S_SUB:   if (!ge) state_nx = S_DONE;
      S_DONE:  if (start) state_nx = S_LDA;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      div_zero <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == S_LDA)
        div_zero <= 1'b0;
      else if (setq)
        div_zero <= 1'b1;
    end
  end

  div_datapath #(
    .WIDTH(WIDTH)
  ) u_dp (
    .clk      (clk),
    .rst      (rst),
    .data_in  (data_in),
    .ldr      (ldr),
    .ldb      (ldb),
    .clrq     (clrq),
    .decr     (decr),
    .incq     (incq),
    .setq     (setq),
    .ge       (ge),
    .bz       (bz),
    .quotient (quotient),
    .remainder(remainder)
  );

endmodule

// File: tb/tb_div_repeated_sub.sv
// Directed self-checking bench for div_repeated_sub.
// Expected values are hand-computed constants.
module tb_div_repeated_sub;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] data_in;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        busy;
  logic        done;
  logic        div_zero;

  int tests;
  int fails;

  div_repeated_sub #(.WIDTH(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .data_in  (data_in),
    .quotient (quotient),
    .remainder(remainder),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full operation from IDLE or DONE; exp_n = edges after E3 until done.
  task automatic do_div(input string tag, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] eq,
                        input logic [15:0] er, input int exp_n,
                        input logic edz, input bit pulse);
    int n;
    start = 1'b1;
    step();
    start = 1'b0;
    check({tag, "_lda_done"}, {31'd0, done}, 32'd0);
    data_in = a;
    step();
    data_in = b;
    step();
    check({tag, "_ldb_dz"}, {31'd0, div_zero}, 32'd0);
    data_in = 16'h0;
    step();
    n = 0;
    while (!done && n < 70000) begin
      if (pulse && n == 50) start = 1'b1;
      if (pulse && n == 51) start = 1'b0;
      step();
      n++;
    end
    start = 1'b0;
    check({tag, "_cycles"}, n, exp_n);
    check({tag, "_q"}, {16'd0, quotient}, {16'd0, eq});
    check({tag, "_r"}, {16'd0, remainder}, {16'd0, er});
    check({tag, "_dz"}, {31'd0, div_zero}, {31'd0, edz});
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    tests   = 0;
    fails   = 0;
    rst     = 1'b1;
    start   = 1'b0;
    data_in = 16'h0;
    step();
    step();
    check("rst_q", {16'd0, quotient}, 32'd0);
    check("rst_r", {16'd0, remainder}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_dz", {31'd0, div_zero}, 32'd0);
    rst = 1'b0;
    step();
    check("idle_busy", {31'd0, busy}, 32'd0);

    do_div("t1_17_5", 16'd17, 16'd5, 16'd3, 16'd2, 4, 1'b0, 1'b0);
    do_div("t2_5_17", 16'd5, 16'd17, 16'd0, 16'd5, 1, 1'b0, 1'b0);
    do_div("t3_20_5", 16'd20, 16'd5, 16'd4, 16'd0, 5, 1'b0, 1'b0);
    do_div("t4_9_0", 16'd9, 16'd0, 16'hFFFF, 16'd9, 0, 1'b1, 1'b0);

    step();
    step();
    check("hold_done", {31'd0, done}, 32'd1);
    check("hold_q", {16'd0, quotient}, 32'h0000FFFF);

    // 100/3 interrupted by reset mid-SUB
    start = 1'b1;
    step();
    start = 1'b0;
    check("t5_lda_done", {31'd0, done}, 32'd0);
    check("t5_lda_busy", {31'd0, busy}, 32'd1);
    data_in = 16'd100;
    step();
    data_in = 16'd3;
    step();
    check("t5_ldb_dz", {31'd0, div_zero}, 32'd0);
    step();
    step();
    step();
    step();
    check("t5_sub_q", {16'd0, quotient}, 32'd3);
    check("t5_sub_r", {16'd0, remainder}, 32'd91);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t5_rst_q", {16'd0, quotient}, 32'd0);
    check("t5_rst_r", {16'd0, remainder}, 32'd0);
    check("t5_rst_busy", {31'd0, busy}, 32'd0);
    check("t5_rst_done", {31'd0, done}, 32'd0);
    check("t5_rst_dz", {31'd0, div_zero}, 32'd0);
    step();
    check("t5_idle_busy", {31'd0, busy}, 32'd0);

    do_div("t5_12_4", 16'd12, 16'd4, 16'd3, 16'd0, 4, 1'b0, 1'b0);
    do_div("t6_max_1", 16'hFFFF, 16'd1, 16'hFFFF, 16'd0, 65536,
           1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
